rod_motion_ctrl: RTL and testbench

Motion and pixel-addressing stage feeding the rod sprite drawer. It owns the rod's vertical position and moves it between a raised and a lowered rest position, one step per video frame, while its trigger input (lever or pressure-plate state from game logic) is held. For each scan pixel it produces the sprite ROM address and a one-cycle-delayed `sprite_on` qualifier, aligned with the drawer's registered RGB, for the layer mux.

---
 rtl/rod_pkg.sv | 20 ++
 rtl/rod_motion_ctrl_vsync_edge.sv | 26 ++
 rtl/rod_motion_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rod_motion_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rod_pkg.sv
// rod_pkg: shared types and default geometry for the rod motion stage.
//   rod_state_t  - motion FSM states
//   *_DEF        - default sprite geometry and travel limits (screen pixels)
package rod_pkg;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    LOWERING = 2'd1,
    DOWN     = 2'd2,
    RAISING  = 2'd3
  } rod_state_t;

  localparam int unsigned ROD_X0_DEF = 18;
  localparam int unsigned ROD_W_DEF  = 64;
  localparam int unsigned ROD_H_DEF  = 10;
  localparam int unsigned Y_UP_DEF   = 258;
  localparam int unsigned Y_DOWN_DEF = 322;
  localparam int unsigned STEP_DEF   = 2;

endpackage

// File: rtl/rod_motion_ctrl_vsync_edge.sv
// vsync_edge: one-cycle frame tick on the falling edge of VGA vsync.
//   vga_clk  in  pixel clock
//   reset_n  in  asynchronous active-low reset
//   vs       in  vsync, active low, synchronous to vga_clk
//   tick     out high for the single cycle in which vs first reads low
module vsync_edge (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic vs,
  output logic tick
);

  logic vs_prev_r;

  // Remember last cycle's vsync level; reset high so no spurious tick after reset
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_r <= 1'b1;
    end else begin
      vs_prev_r <= vs;
    end
  end

  assign tick = vs_prev_r & ~vs;

endmodule

// File: rtl/rod_motion_ctrl.sv
// rod_motion_ctrl: moves the rod between its raised and lowered rest rows,
// one STEP per frame while hold requests it, and addresses the rod sprite ROM.
//   vga_clk      in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   vs           in   vsync (active low), source of the per-frame tick
//   hold         in   1 = travel to / stay at Y_DOWN, 0 = travel to / stay at Y_UP
//   DrawX/DrawY  in   current scan pixel
//   rom_address  out  sprite ROM address (combinational, 0 outside the rod)
//   sprite_on    out  registered in-rod flag aligned with the drawer's RGB
//   rod_y        out  registered top row of the rod
//   moving       out  registered, 1 while travelling
//   at_bottom    out  registered, 1 only when resting at Y_DOWN
module rod_motion_ctrl
  import rod_pkg::*;
#(
  parameter int unsigned ROD_X0 = ROD_X0_DEF,
  parameter int unsigned ROD_W  = ROD_W_DEF,
  parameter int unsigned ROD_H  = ROD_H_DEF,
  parameter int unsigned Y_UP   = Y_UP_DEF,
  parameter int unsigned Y_DOWN = Y_DOWN_DEF,
  parameter int unsigned STEP   = STEP_DEF
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       hold,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_address,
  output logic       sprite_on,
  output logic [9:0] rod_y,
  output logic       moving,
  output logic       at_bottom
);

  localparam logic [9:0]  X0_10     = 10'(ROD_X0);
  localparam logic [9:0]  W_10      = 10'(ROD_W);
  localparam logic [9:0]  H_10      = 10'(ROD_H);
  localparam logic [9:0]  Y_UP_10   = 10'(Y_UP);
  localparam logic [9:0]  Y_DOWN_10 = 10'(Y_DOWN);
  localparam logic [9:0]  STEP_10   = 10'(STEP);
  localparam logic [10:0] STEP_11   = 11'(STEP);

  logic       tick_s;
  rod_state_t state_r;
  rod_state_t state_next_s;
  logic [9:0] rod_y_r;
  logic [9:0] rod_y_next_s;
  logic [10:0] y_plus_s;
  logic [9:0] y_lower_s;
  logic [9:0] y_raise_s;
  logic       moving_r;
  logic       at_bottom_r;
  logic       sprite_on_r;
  logic [9:0] dx_s;
  logic [9:0] dy_s;
  logic       in_box_s;

  vsync_edge u_vsync_edge (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vs      (vs),
    .tick    (tick_s)
  );

  // Clamped candidate positions for one step down / up; 11-bit sum so Y_DOWN+STEP cannot wrap
  always_comb begin
    y_plus_s = {1'b0, rod_y_r} + STEP_11;
    if (y_plus_s >= {1'b0, Y_DOWN_10}) begin
      y_lower_s = Y_DOWN_10;
    end else begin
      y_lower_s = y_plus_s[9:0];
    end
    // Compare before subtracting so a large STEP never underflows below Y_UP
    if ({1'b0, rod_y_r} <= ({1'b0, Y_UP_10} + STEP_11)) begin
      y_raise_s = Y_UP_10;
    end else begin
      y_raise_s = rod_y_r - STEP_10;
    end
  end

  // Motion FSM next state; a hold change wins over a same-cycle tick, so reversals never step
  always_comb begin
    state_next_s = state_r;
    rod_y_next_s = rod_y_r;
    case (state_r)
      UP: begin
        if (hold) begin
          state_next_s = LOWERING;
        end else begin
          state_next_s = UP;
        end
      end
      LOWERING: begin
        if (!hold) begin
          state_next_s = RAISING;
        end else if (tick_s) begin
          rod_y_next_s = y_lower_s;
          if (y_lower_s == Y_DOWN_10) begin
            state_next_s = DOWN;
          end else begin
            state_next_s = LOWERING;
          end
        end else begin
          state_next_s = LOWERING;
        end
      end
      DOWN: begin
        if (!hold) begin
          state_next_s = RAISING;
        end else begin
          state_next_s = DOWN;
        end
      end
      RAISING: begin
        if (hold) begin
          state_next_s = LOWERING;
        end else if (tick_s) begin
          rod_y_next_s = y_raise_s;
          if (y_raise_s == Y_UP_10) begin
            state_next_s = UP;
          end else begin
            state_next_s = RAISING;
          end
        end else begin
          state_next_s = RAISING;
        end
      end
      default: begin
        state_next_s = UP;
        rod_y_next_s = Y_UP_10;
      end
    endcase
  end

  // Pixel window test; unsigned 10-bit differences make left/above the rod read as outside
  always_comb begin
    dx_s     = DrawX - X0_10;
    dy_s     = DrawY - rod_y_r;
    in_box_s = (dx_s < W_10) && (dy_s < H_10);
    if (in_box_s) begin
      rom_address = dx_s + (dy_s * W_10);
    end else begin
      rom_address = 10'd0;
    end
  end

  // State, position and status flags; flags decode the next state so they track state_r exactly
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= UP;
      rod_y_r     <= Y_UP_10;
      moving_r    <= 1'b0;
      at_bottom_r <= 1'b0;
      sprite_on_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rod_y_r     <= rod_y_next_s;
      moving_r    <= (state_next_s == LOWERING) || (state_next_s == RAISING);
      at_bottom_r <= (state_next_s == DOWN);
      sprite_on_r <= in_box_s;
    end
  end

  assign rod_y     = rod_y_r;
  assign moving    = moving_r;
  assign at_bottom = at_bottom_r;
  assign sprite_on = sprite_on_r;

endmodule

// File: tb/tb_rod_motion_ctrl.sv
// Scoreboard bench for rod_motion_ctrl: two instances (STEP=2 and STEP=3) share
// stimulus; a frame-level reference model predicts every cycle's outputs.
module tb_rod_motion_ctrl;

  localparam int X0     = 18;
  localparam int W      = 64;
  localparam int H      = 10;
  localparam int Y_UP   = 258;
  localparam int Y_DOWN = 322;
  localparam int FRAME  = 12;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       vs;
  logic       hold;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] rom2, rom3, y2, y3;
  logic       on2, on3, mov2, mov3, bot2, bot3;

  always #5 vga_clk = ~vga_clk;

  rod_motion_ctrl #(.STEP(2)) dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs), .hold(hold),
    .DrawX(DrawX), .DrawY(DrawY), .rom_address(rom2), .sprite_on(on2),
    .rod_y(y2), .moving(mov2), .at_bottom(bot2)
  );

  rod_motion_ctrl #(.STEP(3)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs), .hold(hold),
    .DrawX(DrawX), .DrawY(DrawY), .rom_address(rom3), .sprite_on(on3),
    .rod_y(y3), .moving(mov3), .at_bottom(bot3)
  );

  // Reference model: a position, a direction and whether it has settled at a rest row
  typedef struct {
    int y;
    bit dir;
    bit settled;
    bit vs_prev;
    bit on_prev;
  } mdl_t;

  typedef struct {
    int y;
    int mov;
    int bot;
    int on;
    int addr;
  } exp_one_t;

  typedef struct {
    exp_one_t a;
    exp_one_t b;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  mdl_t m2, m3;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.y = Y_UP; m.dir = 1'b0; m.settled = 1'b1; m.vs_prev = 1'b1; m.on_prev = 1'b0;
    return m;
  endfunction

  function automatic bit in_rod(int dx, int dy, int y);
    return (dx >= X0) && (dx < X0 + W) && (dy >= y) && (dy < y + H);
  endfunction

  function automatic int addr_of(int dx, int dy, int y);
    return in_rod(dx, dy, y) ? (dx - X0) + (dy - y) * W : 0;
  endfunction

  function automatic mdl_t mdl_clock(mdl_t m, bit vs_in, bit hold_in, int dx, int dy, int step);
    mdl_t n;
    bit   tick;
    int   goal;
    n = m;
    tick = m.vs_prev && !vs_in;
    if (hold_in != n.dir) begin
      n.dir = hold_in;
      n.settled = 1'b0;
    end else if (!n.settled && tick) begin
      goal = n.dir ? Y_DOWN : Y_UP;
      if (n.dir) n.y = (n.y + step > Y_DOWN) ? Y_DOWN : n.y + step;
      else       n.y = (n.y - step < Y_UP) ? Y_UP : n.y - step;
      if (n.y == goal) n.settled = 1'b1;
    end
    n.on_prev = in_rod(dx, dy, m.y);
    n.vs_prev = vs_in;
    return n;
  endfunction

  function automatic exp_one_t mdl_out(mdl_t m, int dx, int dy);
    exp_one_t e;
    e.y = m.y; e.mov = int'(!m.settled); e.bot = int'(m.settled && m.dir);
    e.on = int'(m.on_prev); e.addr = addr_of(dx, dy, m.y);
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic drv(bit rst, bit vs_in, bit hold_in, int dx, int dy);
    exp_t e;
    @(posedge vga_clk);
    #1;
    reset_n = !rst; vs = vs_in; hold = hold_in;
    DrawX = 10'(dx); DrawY = 10'(dy);
    if (rst) begin
      m2 = mdl_reset(); m3 = mdl_reset();
    end
    e.a = mdl_out(m2, dx, dy);
    e.b = mdl_out(m3, dx, dy);
    sb_q.push_back(e);
    if (rst) begin
      m2 = mdl_reset(); m3 = mdl_reset();
    end else begin
      m2 = mdl_clock(m2, vs_in, hold_in, dx, dy, 2);
      m3 = mdl_clock(m3, vs_in, hold_in, dx, dy, 3);
    end
  endtask

  task automatic pick_pix(output int dx, output int dy);
    if ($urandom_range(0, 7) == 0) begin
      dx = $urandom_range(0, 1023); dy = $urandom_range(0, 1023);
    end else begin
      dx = X0 - 2 + $urandom_range(0, W + 3);
      dy = m2.y - 2 + $urandom_range(0, H + 3);
    end
  endtask

  // One frame: vsync low on cycles 2-3 (tick on cycle 2); hold switches h0->h1 at cycle sw
  task automatic run_frame(bit h0, bit h1, int sw, int rst_pm);
    int dx, dy;
    for (int c = 0; c < FRAME; c++) begin
      pick_pix(dx, dy);
      drv(($urandom_range(0, 999) < rst_pm), !(c == 2 || c == 3), (c >= sw) ? h1 : h0, dx, dy);
    end
  endtask

  task automatic pix(int dx, int dy, int exp_addr, int exp_on);
    drv(1'b0, 1'b1, 1'b0, dx, dy);
    @(negedge vga_clk);
    chk("pix_addr", int'(rom2), exp_addr);
    drv(1'b0, 1'b1, 1'b0, 0, 0);
    @(negedge vga_clk);
    chk("pix_sprite_on", int'(on2), exp_on);
  endtask

  // Monitor: every cycle's outputs against the queued prediction
  always @(negedge vga_clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("s2_rod_y", int'(y2), e.a.y);
      chk("s2_moving", int'(mov2), e.a.mov);
      chk("s2_at_bottom", int'(bot2), e.a.bot);
      chk("s2_sprite_on", int'(on2), e.a.on);
      chk("s2_rom_address", int'(rom2), e.a.addr);
      chk("s3_rod_y", int'(y3), e.b.y);
      chk("s3_moving", int'(mov3), e.b.mov);
      chk("s3_at_bottom", int'(bot3), e.b.bot);
      chk("s3_sprite_on", int'(on3), e.b.on);
      chk("s3_rom_address", int'(rom3), e.b.addr);
    end
  end

  initial begin
    reset_n = 1'b0; vs = 1'b1; hold = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    m2 = mdl_reset(); m3 = mdl_reset();

    repeat (3) drv(1'b1, 1'b1, 1'b0, 0, 0);
    @(negedge vga_clk);
    chk("reset_rod_y", int'(y2), 258);
    chk("reset_moving", int'(mov2), 0);
    chk("reset_sprite_on", int'(on2), 0);

    repeat (3) run_frame(1'b0, 1'b0, 0, 0);
    @(negedge vga_clk);
    chk("idle_rod_y", int'(y2), 258);
    chk("idle_moving", int'(mov2), 0);

    pix(18, 258, 0, 1);
    pix(81, 267, 639, 1);
    pix(82, 267, 0, 0);
    pix(17, 260, 0, 0);
    pix(18, 268, 0, 0);

    // hold rises: state changes one cycle later
    drv(1'b0, 1'b1, 1'b1, 0, 0);
    @(negedge vga_clk);
    chk("hold_latency_before", int'(mov2), 0);
    drv(1'b0, 1'b1, 1'b1, 0, 0);
    @(negedge vga_clk);
    chk("hold_latency_after", int'(mov2), 1);

    for (int f = 1; f <= 32; f++) begin
      run_frame(1'b1, 1'b1, 0, 0);
      @(negedge vga_clk);
      if (f == 1)  chk("lower_tick1", int'(y2), 260);
      if (f == 20) chk("step3_tick20", int'(y3), 318);
      if (f == 21) begin chk("step3_tick21", int'(y3), 321); chk("step3_not_down", int'(bot3), 0); end
      if (f == 22) begin chk("step3_tick22", int'(y3), 322); chk("step3_down", int'(bot3), 1); end
      if (f == 31) chk("lower_tick31_moving", int'(mov2), 1);
    end
    chk("lower_done_rod_y", int'(y2), 322);
    chk("lower_done_at_bottom", int'(bot2), 1);
    chk("lower_done_moving", int'(mov2), 0);

    repeat (33) run_frame(1'b0, 1'b0, 0, 0);
    @(negedge vga_clk);
    chk("raise_done_rod_y", int'(y2), 258);
    chk("raise_done_moving", int'(mov2), 0);

    repeat (5) run_frame(1'b1, 1'b1, 0, 0);
    @(negedge vga_clk);
    chk("five_ticks_rod_y", int'(y2), 268);
    run_frame(1'b1, 1'b0, 2, 0);      // hold falls on the tick cycle
    @(negedge vga_clk);
    chk("reverse_no_step", int'(y2), 268);
    chk("reverse_moving", int'(mov2), 1);
    repeat (5) run_frame(1'b0, 1'b0, 0, 0);
    @(negedge vga_clk);
    chk("back_up_rod_y", int'(y2), 258);
    chk("back_up_moving", int'(mov2), 0);
    chk("back_up_at_bottom", int'(bot2), 0);

    repeat (3) run_frame(1'b1, 1'b1, 0, 0);
    @(negedge vga_clk);
    chk("pre_reset_rod_y", int'(y2), 264);
    drv(1'b1, 1'b1, 1'b1, 0, 0);
    @(negedge vga_clk);
    chk("midtravel_reset_rod_y", int'(y2), 258);
    chk("midtravel_reset_moving", int'(mov2), 0);
    drv(1'b0, 1'b1, 1'b0, 0, 0);

    for (int f = 0; f < 80; f++) begin
      int sw;
      case ($urandom_range(0, 3))
        0: sw = 2;
        1: sw = 3;
        default: sw = $urandom_range(0, FRAME - 1);
      endcase
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sw, 3);
    end

    @(negedge vga_clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
